// File: rtl/lora_tx_pkg.sv
// Shared LoRa TX definitions: chirp codes, SF select codes, frame FSM states.
package lora_tx_pkg;

  localparam logic [1:0] CHIRP_UP    = 2'b00;
  localparam logic [1:0] CHIRP_DOWN  = 2'b01;
  localparam logic [1:0] CHIRP_QDOWN = 2'b10;

  // sf_select code n selects SF(n+5), covering SF5..SF12
  localparam logic [2:0] SF_SEL_5  = 3'd0;
  localparam logic [2:0] SF_SEL_6  = 3'd1;
  localparam logic [2:0] SF_SEL_7  = 3'd2;
  localparam logic [2:0] SF_SEL_8  = 3'd3;
  localparam logic [2:0] SF_SEL_9  = 3'd4;
  localparam logic [2:0] SF_SEL_10 = 3'd5;
  localparam logic [2:0] SF_SEL_11 = 3'd6;
  localparam logic [2:0] SF_SEL_12 = 3'd7;

  localparam int MASK_W     = 16;
  localparam int SYNC_SHIFT = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_DOWN     = 3'd3,
    ST_QDOWN    = 3'd4,
    ST_PAYLOAD  = 3'd5
  } seq_state_t;

  function automatic logic [3:0] sf_value(input logic [2:0] sel);
    return 4'(sel) + 4'd5;
  endfunction

  function automatic logic [MASK_W-1:0] sf_mask(input logic [2:0] sel);
    logic [31:0] full_mask;
    full_mask = (32'd1 << sf_value(sel)) - 32'd1;
    return full_mask[MASK_W-1:0];
  endfunction

endpackage

// File: rtl/lora_sym_slot.sv
// One-entry prefetch buffer between the symbol stream and the frame sequencer.
module lora_sym_slot #(
  parameter int SYM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             take,
  input  logic             fill_ok,
  input  logic [SYM_W-1:0] s_sym,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             accept,
  output logic             full,
  output logic [SYM_W-1:0] data
);

  logic full_n;

  assign accept = s_valid & s_ready;

  always_comb begin
    full_n = full;
    if (flush || take) full_n = 1'b0;
    else if (accept)   full_n = 1'b1;
  end

  // ready is computed from the next slot state, so a take and a refill never share a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      data    <= '0;
      s_ready <= 1'b0;
    end else begin
      full <= full_n;
      if (accept) data <= s_sym;
      s_ready <= fill_ok & ~full_n & ~flush;
    end
  end

endmodule

// File: rtl/lora_frame_sequencer.sv
// Builds one LoRa frame (preamble, sync, down, quarter-down, payload) as a
// stream of symbol value / chirp type pairs, advancing on each modulator sym_done.
module lora_frame_sequencer
  import lora_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 8,
  parameter int SYM_W        = 12,
  parameter int LEN_W        = 8,
  parameter int SFSEL_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [SFSEL_W-1:0] sf_select,
  input  logic [7:0]         sync_word,
  input  logic [LEN_W-1:0]   pay_len,
  input  logic [SYM_W-1:0]   s_sym,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [SYM_W-1:0]   sym_val,
  output logic [1:0]         sym_type,
  output logic               mod_en,
  input  logic               sym_done,
  output logic               busy,
  output logic               frame_done,
  output logic               underflow
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

  seq_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   rem, rem_n;
  logic [LEN_W-1:0]   fetched, fetched_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [SFSEL_W-1:0] sf_q, sf_n;
  logic [7:0]         sync_q, sync_n;

  logic [SYM_W-1:0]   sym_val_n;
  logic [1:0]         sym_type_n;
  logic               mod_en_n, busy_n, frame_done_n, underflow_n;

  logic               take, ev_start, ev_end, ev_uf;
  logic               slot_full, slot_accept, fill_ok_n, flush;
  logic [SYM_W-1:0]   slot_data, sym_mask;

  assign sym_mask  = SYM_W'(sf_mask(sf_q));
  assign flush     = abort | ev_end | ev_uf;
  assign fetched_n = ev_start ? '0 : fetched + LEN_W'(slot_accept);
  assign fill_ok_n = (state_n inside {ST_SYNC, ST_DOWN, ST_QDOWN, ST_PAYLOAD}) &&
                     (fetched_n < len_n);

  lora_sym_slot #(.SYM_W(SYM_W)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .take    (take),
    .fill_ok (fill_ok_n),
    .s_sym   (s_sym),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .accept  (slot_accept),
    .full    (slot_full),
    .data    (slot_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rem        <= '0;
      fetched    <= '0;
      len_q      <= '0;
      sf_q       <= '0;
      sync_q     <= '0;
      sym_val    <= '0;
      sym_type   <= CHIRP_UP;
      mod_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rem        <= rem_n;
      fetched    <= fetched_n;
      len_q      <= len_n;
      sf_q       <= sf_n;
      sync_q     <= sync_n;
      sym_val    <= sym_val_n;
      sym_type   <= sym_type_n;
      mod_en     <= mod_en_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      underflow  <= underflow_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    len_n    = len_q;
    sf_n     = sf_q;
    sync_n   = sync_q;
    take     = 1'b0;
    ev_start = 1'b0;
    ev_end   = 1'b0;
    ev_uf    = 1'b0;
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state_n  = ST_PREAMBLE;
          cnt_n    = '0;
          len_n    = pay_len;
          sf_n     = sf_select;
          sync_n   = sync_word;
          ev_start = 1'b1;
        end
        ST_PREAMBLE: if (sym_done) begin
          if (cnt == PRE_LAST) begin
            state_n = ST_SYNC;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_SYNC, ST_DOWN: if (sym_done) begin
          if (cnt == CNT_W'(1)) begin
            state_n = (state == ST_SYNC) ? ST_DOWN : ST_QDOWN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_QDOWN: if (sym_done) begin
          if (len_q == '0) begin
            state_n = ST_IDLE;
            ev_end  = 1'b1;
          end else if (slot_full) begin
            state_n = ST_PAYLOAD;
            take    = 1'b1;
            rem_n   = len_q - LEN_W'(1);
          end else begin
            state_n = ST_IDLE;
            ev_uf   = 1'b1;
          end
        end
        ST_PAYLOAD: if (sym_done) begin
          if (rem == '0) begin
            state_n = ST_IDLE;
            ev_end  = 1'b1;
          end else if (slot_full) begin
            take  = 1'b1;
            rem_n = rem - LEN_W'(1);
          end else begin
            state_n = ST_IDLE;
            ev_uf   = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_val_n    = sym_val;
    sym_type_n   = sym_type;
    mod_en_n     = mod_en;
    busy_n       = busy;
    frame_done_n = 1'b0;
    underflow_n  = underflow;
    if (abort || ev_end || ev_uf) begin
      sym_val_n    = '0;
      sym_type_n   = CHIRP_UP;
      mod_en_n     = 1'b0;
      busy_n       = 1'b0;
      frame_done_n = ev_end;
      if (ev_uf) underflow_n = 1'b1;
    end else if (ev_start) begin
      sym_val_n   = '0;
      sym_type_n  = CHIRP_UP;
      mod_en_n    = 1'b1;
      busy_n      = 1'b1;
      underflow_n = 1'b0;
    end else if (sym_done) begin
      case (state)
        ST_PREAMBLE: if (state_n == ST_SYNC) begin
          sym_type_n = CHIRP_UP;
          sym_val_n  = SYM_W'(sync_q[7:4]) << SYNC_SHIFT;
        end
        ST_SYNC: begin
          if (state_n == ST_SYNC) begin
            sym_val_n = SYM_W'(sync_q[3:0]) << SYNC_SHIFT;
          end else begin
            sym_type_n = CHIRP_DOWN;
            sym_val_n  = '0;
          end
        end
        ST_DOWN: if (state_n == ST_QDOWN) begin
          sym_type_n = CHIRP_QDOWN;
          sym_val_n  = '0;
        end
        ST_QDOWN, ST_PAYLOAD: if (take) begin
          sym_type_n = CHIRP_UP;
          sym_val_n  = slot_data & sym_mask;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lora_frame_sequencer.sv
// Directed bench: per-frame tables of expected (type, value) symbols plus hand sequences.
module tb_lora_frame_sequencer;
  import lora_tx_pkg::*;

  localparam int SYM_W = 12;
  localparam int LEN_W = 8;
  localparam int GAP   = 20;

  logic             clk = 1'b0;
  logic             rst, start, abort, s_valid, sym_done;
  logic [2:0]       sf_select;
  logic [7:0]       sync_word;
  logic [LEN_W-1:0] pay_len;
  logic [SYM_W-1:0] s_sym, sym_val;
  logic             s_ready, mod_en, busy, frame_done, underflow;
  logic [1:0]       sym_type;

  always #5 clk = ~clk;

  lora_frame_sequencer #(.PREAMBLE_LEN(8), .SYM_W(SYM_W), .LEN_W(LEN_W), .SFSEL_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sf_select(sf_select),
    .sync_word(sync_word), .pay_len(pay_len), .s_sym(s_sym), .s_valid(s_valid),
    .s_ready(s_ready), .sym_val(sym_val), .sym_type(sym_type), .mod_en(mod_en),
    .sym_done(sym_done), .busy(busy), .frame_done(frame_done), .underflow(underflow)
  );

  typedef struct {
    int               scen;
    logic [1:0]       typ;
    logic [SYM_W-1:0] val;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // upstream symbol source
  logic             up_en = 1'b0;
  int               up_idx = 0, up_n = 0, acc_cnt = 0, ready_cnt = 0;
  logic             acc_prev = 1'b0;
  logic [SYM_W-1:0] up_data[4];

  initial begin
    s_valid = 1'b0;
    s_sym   = '0;
    forever begin
      @(negedge clk);
      if (acc_prev) begin
        up_idx++;
        acc_cnt++;
      end
      if (up_en && up_idx < up_n) begin
        s_valid = 1'b1;
        s_sym   = up_data[up_idx];
      end else begin
        s_valid = 1'b0;
        s_sym   = '0;
      end
      acc_prev = s_valid && s_ready;
      if (s_ready) ready_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int scen, input logic [1:0] typ, input logic [SYM_W-1:0] val);
    vec_t v;
    v.scen = scen;
    v.typ  = typ;
    v.val  = val;
    vecs.push_back(v);
  endtask

  task automatic add_hdr(input int scen, input logic [SYM_W-1:0] s_hi, input logic [SYM_W-1:0] s_lo);
    for (int k = 0; k < 8; k++) add(scen, 2'b00, 12'd0);
    add(scen, 2'b00, s_hi);
    add(scen, 2'b00, s_lo);
    add(scen, 2'b01, 12'd0);
    add(scen, 2'b01, 12'd0);
    add(scen, 2'b10, 12'd0);
  endtask

  // plays table entries [from, to) of one scenario as a modulator would
  task automatic play(input int scen, input int from, input int to);
    int k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        if (k >= from && k < to) begin
          repeat (GAP - 1) @(negedge clk);
          check($sformatf("s%0d sym%0d {mod_en,type,val}", scen, k),
                32'({mod_en, sym_type, sym_val}), 32'({1'b1, vecs[i].typ, vecs[i].val}));
          sym_done = 1'b1;
          @(negedge clk);
          sym_done = 1'b0;
        end
        k++;
      end
    end
  endtask

  task automatic load_up(input logic [SYM_W-1:0] d0, d1, d2, d3, input int n, input logic en);
    up_en = 1'b0;
    repeat (2) @(negedge clk);
    up_idx     = 0;
    acc_cnt    = 0;
    ready_cnt  = 0;
    up_data[0] = d0;
    up_data[1] = d1;
    up_data[2] = d2;
    up_data[3] = d3;
    up_n       = n;
    up_en      = en;
  endtask

  task automatic start_frame(input logic [2:0] sf, input logic [7:0] sw, input logic [LEN_W-1:0] len);
    @(negedge clk);
    sf_select = sf;
    sync_word = sw;
    pay_len   = len;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start latency {busy,mod_en,underflow,type,val}",
          32'({busy, mod_en, underflow, sym_type, sym_val}), 32'({1'b1, 1'b1, 1'b0, 2'b00, 12'd0}));
  endtask

  task automatic check_end(input string name);
    check({name, " end {frame_done,busy,mod_en,type,val}"},
          32'({frame_done, busy, mod_en, sym_type, sym_val}), 32'({1'b1, 1'b0, 1'b0, 2'b00, 12'd0}));
    @(negedge clk);
    check({name, " frame_done one cycle"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    add_hdr(1, 12'd24, 12'd32);
    add(1, 2'b00, 12'd5);
    add(1, 2'b00, 12'd127);
    add(1, 2'b00, 12'd72);
    add_hdr(2, 12'd8, 12'd16);
    add_hdr(3, 12'd24, 12'd32);

    rst = 1'b0; start = 1'b0; abort = 1'b0; sym_done = 1'b0;
    sf_select = SF_SEL_7; sync_word = 8'h00; pay_len = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({s_ready, underflow, frame_done, busy, mod_en, sym_type, sym_val}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // sym_done in IDLE must not start anything
    sym_done = 1'b1;
    @(negedge clk);
    sym_done = 1'b0;
    @(negedge clk);
    check("idle sym_done ignored {busy,mod_en,val}", 32'({busy, mod_en, sym_val}), 32'd0);

    // full frame, SF7, 200 masked to 72, fourth offered symbol must not be taken
    load_up(12'd5, 12'd127, 12'd200, 12'd9, 4, 1'b1);
    start_frame(SF_SEL_7, 8'h34, 8'd3);
    play(1, 0, 99);
    check_end("s1");
    check("s1 accepted symbols", 32'(acc_cnt), 32'd3);

    // pay_len=0 with a start pulse mid-preamble carrying other settings
    load_up(12'd1, 12'd2, 12'd3, 12'd4, 2, 1'b1);
    start_frame(SF_SEL_7, 8'h12, 8'd0);
    play(2, 0, 3);
    sync_word = 8'hAB;
    pay_len   = 8'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy start ignored {busy,mod_en}", 32'({busy, mod_en}), 32'd3);
    play(2, 3, 99);
    check_end("s2");
    check("s2 s_ready never asserted", 32'(ready_cnt), 32'd0);
    check("s2 accepted symbols", 32'(acc_cnt), 32'd0);

    // underflow: nothing offered through QDOWN
    load_up(12'd0, 12'd0, 12'd0, 12'd0, 0, 1'b0);
    start_frame(SF_SEL_7, 8'h34, 8'd2);
    play(3, 0, 99);
    check("s3 underflow {underflow,frame_done,busy,mod_en}",
          32'({underflow, frame_done, busy, mod_en}), 32'b1000);
    @(negedge clk);
    check("s3 sticky {underflow,frame_done}", 32'({underflow, frame_done}), 32'b10);
    start_frame(SF_SEL_7, 8'h34, 8'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s3 abort cleanup {busy,mod_en}", 32'({busy, mod_en}), 32'd0);

    // abort in the 4th preamble symbol, restart two cycles later
    load_up(12'd5, 12'd127, 12'd200, 12'd9, 4, 1'b1);
    start_frame(SF_SEL_7, 8'h34, 8'd3);
    play(1, 0, 3);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("s4 abort {busy,mod_en,frame_done}", 32'({busy, mod_en, frame_done}), 32'd0);
    play(1, 16, 16);
    start_frame(SF_SEL_7, 8'h34, 8'd3);
    play(1, 0, 99);
    check_end("s4");
    check("s4 accepted symbols", 32'(acc_cnt), 32'd3);

    // async reset mid-PAYLOAD
    load_up(12'd5, 12'd127, 12'd200, 12'd9, 4, 1'b1);
    start_frame(SF_SEL_7, 8'h34, 8'd3);
    play(1, 0, 13);
    check("s6 in payload {type,val}", 32'({sym_type, sym_val}), 32'({2'b00, 12'd5}));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("s6 async reset outputs",
             32'({s_ready, underflow, frame_done, busy, mod_en, sym_type, sym_val}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load_up(12'd0, 12'd0, 12'd0, 12'd0, 0, 1'b0);
    start_frame(SF_SEL_7, 8'h12, 8'd0);
    play(2, 0, 99);
    check_end("s6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
